keypad_scanner: RTL and testbench

Scans a 4x4 passive key matrix by driving one column low at a time and sampling the row lines. It debounces the result and rejects multi-key (ghost) frames. For each confirmed press it reports exactly one key code with a single-cycle strobe. It is the input-side counterpart of the multiplexed 7-segment display path, shares the board clock, and feeds key codes to the BCD control logic.

---
 rtl/keypad_scanner.sv | 171 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 key matrix scanner. Drives one column low at a time,
// samples the synchronized rows, rejects multi-key frames and debounces
// single-key frames into one key_valid strobe per confirmed press.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned   PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [3:0]    DB_CNT    = 4'(DEBOUNCE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONFIRM,
    S_PRESSED,
    S_RELEASE
  } state_t;

  logic [3:0]    row_s1;
  logic [3:0]    row_s2;
  logic [PW-1:0] presc;
  logic [1:0]    col_idx;
  logic [15:0]   acc;
  state_t        state;
  logic [3:0]    cand;
  logic [3:0]    cnt;

  logic          tick_c;
  logic          frame_done_c;
  logic [15:0]   frame_bits_c;
  logic [4:0]    n_keys_c;
  logic [3:0]    frame_code_c;
  logic          single_c;
  logic          match_c;

  assign tick_c       = (presc == PRESC_MAX);
  assign frame_done_c = tick_c && (col_idx == 2'd3);
  assign single_c     = (n_keys_c == 5'd1);
  assign match_c      = single_c && (frame_code_c == cand);

  // Two-flop synchronizer for the asynchronous row lines (idle = all high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
    end
  end

  // Frame bits so far, with the current column's rows merged in (active-high)
  always_comb begin
    frame_bits_c = acc;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (col_idx == 2'(c)) frame_bits_c[4*r + c] = ~row_s2[r];
      end
    end
  end

  // Pressed-key count and the code of the (last) pressed key in the frame
  always_comb begin
    n_keys_c     = '0;
    frame_code_c = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame_bits_c[i]) begin
        n_keys_c     = n_keys_c + 5'd1;
        frame_code_c = 4'(i);
      end
    end
  end

  // Prescaler, column walk and frame accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      col_idx <= 2'd0;
      col     <= 4'b1110;
      acc     <= '0;
    end else if (tick_c) begin
      presc   <= '0;
      col_idx <= col_idx + 2'd1;
      col     <= ~(4'b0001 << (col_idx + 2'd1));
      acc     <= (col_idx == 2'd3) ? 16'h0000 : frame_bits_c;
    end else begin
      presc   <= presc + PW'(1);
    end
  end

  // Debounce FSM, advanced once per completed frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cand      <= '0;
      cnt       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_done_c) begin
        unique case (state)
          S_IDLE: begin
            if (single_c) begin
              cand <= frame_code_c;
              cnt  <= 4'd1;
              if (DB_CNT == 4'd1) begin
                state     <= S_PRESSED;
                key_code  <= frame_code_c;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end else begin
                state <= S_CONFIRM;
              end
            end
          end
          S_CONFIRM: begin
            if (match_c) begin
              cnt <= cnt + 4'd1;
              if (cnt + 4'd1 == DB_CNT) begin
                state     <= S_PRESSED;
                key_code  <= cand;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end
            end else if (single_c) begin
              cand <= frame_code_c;
              cnt  <= 4'd1;
            end else begin
              state <= S_IDLE;
            end
          end
          S_PRESSED: begin
            if (!match_c) begin
              cnt <= 4'd1;
              if (DB_CNT == 4'd1) begin
                state    <= S_IDLE;
                key_held <= 1'b0;
              end else begin
                state <= S_RELEASE;
              end
            end
          end
          S_RELEASE: begin
            if (match_c) begin
              state <= S_PRESSED;
            end else begin
              cnt <= cnt + 4'd1;
              if (cnt + 4'd1 == DB_CNT) begin
                state    <= S_IDLE;
                key_held <= 1'b0;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed and randomized key stimulus through a matrix
// model, checked against a frame-level behavioural reference of the scanner.
module tb_keypad_scanner;

  localparam int SD = 8;
  localparam int DB = 3;
  localparam int FR = 4 * SD;

  logic       clk;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys;
  int tests = 0;
  int fails = 0;
  int pulses = 0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Passive matrix: a pressed key pulls its row low while its column is driven low
  always_comb begin
    row = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      if (keys[i] && (col[i % 4] === 1'b0)) row[i / 4] = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: per-cycle key history, frames of 16 sampled bits,
  // debounce expressed as run lengths of identical / differing frames
  int          m;
  int          m_cand;
  int          m_run;
  bit          m_held;
  int          e_pulses = 0;
  logic [15:0] kd1, kd2, fmask;
  logic [3:0]  e_code, e_col;
  logic        e_valid, e_held;

  always @(negedge clk) begin : model
    int c, n, f;
    if (!rst_n) begin
      m = 0; m_cand = -1; m_run = 0; m_held = 0;
      kd1 = '0; kd2 = '0; fmask = '0;
      e_code = '0; e_valid = 1'b0; e_held = 1'b0; e_col = 4'b1110;
      check("m_col", col, e_col);
      check("m_code", key_code, e_code);
      check("m_valid", key_valid, e_valid);
      check("m_held", key_held, e_held);
    end else begin
      e_col = 4'b1111;
      e_col[(m / SD) % 4] = 1'b0;
      check("m_col", col, e_col);
      check("m_code", key_code, e_code);
      check("m_valid", key_valid, e_valid);
      check("m_held", key_held, e_held);
      e_valid = 1'b0;
      if (m % SD == SD - 1) begin
        c = (m / SD) % 4;
        for (int r = 0; r < 4; r++) if (kd2[4*r + c]) fmask[4*r + c] = 1'b1;
        if (c == 3) begin
          n = $countones(fmask);
          f = -1;
          if (n == 1) for (int i = 0; i < 16; i++) if (fmask[i]) f = i;
          if (!m_held) begin
            if (f < 0) begin m_cand = -1; m_run = 0; end
            else if (f == m_cand) m_run++;
            else begin m_cand = f; m_run = 1; end
            if (m_run >= DB) begin
              m_held = 1; m_run = 0; e_valid = 1'b1;
              e_code = 4'(m_cand); e_pulses++;
            end
          end else begin
            if (f == m_cand) m_run = 0; else m_run++;
            if (m_run >= DB) begin m_held = 0; m_cand = -1; m_run = 0; end
          end
          fmask = '0;
        end
      end
      e_held = m_held;
      kd2 = kd1;
      kd1 = keys;
      m++;
    end
  end

  // Strobe counter
  always @(negedge clk) begin
    if (rst_n && key_valid === 1'b1) pulses++;
  end

  task automatic wait_frame_start();
    do @(posedge clk); while (m % FR != 0);
    #1;
  endtask

  task automatic wait_valid(input int limit, output int cyc, output bit found);
    found = 1'b0;
    for (cyc = 0; cyc <= limit; cyc++) begin
      @(negedge clk);
      if (key_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [3:0] walk [5];
    int  cyc, p0, gap, hold, k, k2;
    bit  found;
    walk = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // Reset
    keys = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col", col, 4'b1110);
    check("rst_code", key_code, 4'd0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held", key_held, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    repeat (4) @(negedge clk);
    check("walk0", col, walk[0]);
    for (int s = 1; s < 5; s++) begin
      repeat (SD) @(negedge clk);
      check($sformatf("walk%0d", s), col, walk[s]);
    end

    // Stable press of key 9 (row 2, col 1)
    repeat ($urandom_range(0, 40)) @(posedge clk);
    #1 keys = 16'h0200;
    wait_valid(140, cyc, found);
    check("press_found", found, 1'b1);
    check("press_latency_ok", cyc <= (DB + 1) * FR + 3, 1'b1);
    check("press_code", key_code, 4'd9);
    check("press_held", key_held, 1'b1);
    @(posedge clk);
    p0 = pulses;
    repeat (10 * FR) @(negedge clk);
    @(posedge clk);
    check("hold_no_repeat", pulses, p0);
    check("hold_held", key_held, 1'b1);

    // One-frame release then re-press
    wait_frame_start();
    keys = '0;
    repeat (FR) @(posedge clk);
    #1 keys = 16'h0200;
    repeat (2 * FR) @(negedge clk);
    @(posedge clk);
    check("blip_held", key_held, 1'b1);
    check("blip_no_strobe", pulses, p0);

    // Full release
    #1 keys = '0;
    repeat (4 * FR + 10) @(negedge clk);
    @(posedge clk);
    check("rel_held", key_held, 1'b0);
    check("rel_code_kept", key_code, 4'd9);
    check("rel_no_strobe", pulses, p0);

    // Ghost: keys 0 and 5 together, then release 5
    wait_frame_start();
    keys = 16'h0021;
    p0 = pulses;
    repeat (8 * FR) @(negedge clk);
    @(posedge clk);
    check("ghost_no_strobe", pulses, p0);
    check("ghost_held", key_held, 1'b0);
    #1 keys = 16'h0001;
    wait_valid(5 * FR, cyc, found);
    check("ghost_rel_found", found, 1'b1);
    check("ghost_rel_code", key_code, 4'd0);
    @(posedge clk);
    check("ghost_rel_once", pulses, p0 + 1);
    #1 keys = '0;
    repeat (5 * FR) @(negedge clk);

    // Bounce key 9 every 20 cycles for 3 frames, then stable
    wait_frame_start();
    p0 = pulses;
    for (int t = 0; t < 3 * FR; t++) begin
      keys = ((t / 20) % 2 == 0) ? 16'h0200 : 16'h0000;
      @(posedge clk); #1;
    end
    keys = 16'h0200;
    check("bounce_no_strobe", pulses, p0);
    wait_valid(5 * FR, cyc, found);
    check("bounce_found", found, 1'b1);
    check("bounce_code", key_code, 4'd9);
    @(posedge clk);
    check("bounce_once", pulses, p0 + 1);
    #1 keys = '0;
    repeat (5 * FR) @(negedge clk);

    // Reset while confirming a held key
    wait_frame_start();
    keys = 16'h0200;
    repeat (2 * FR + 4) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("arst_col", col, 4'b1110);
    check("arst_code", key_code, 4'd0);
    check("arst_valid", key_valid, 1'b0);
    check("arst_held", key_held, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_valid(5 * FR, cyc, found);
    check("arst_found", found, 1'b1);
    check("arst_fresh_frames", cyc, DB * FR);
    check("arst_code9", key_code, 4'd9);

    // Randomized presses, occasional ghost pairs
    @(posedge clk); #1;
    for (int it = 0; it < 12; it++) begin
      keys = '0;
      gap = $urandom_range(0, 100);
      repeat (gap) @(posedge clk);
      #1;
      k = $urandom_range(0, 15);
      keys = '0;
      keys[k] = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        k2 = (k + 1 + $urandom_range(0, 14)) % 16;
        keys[k2] = 1'b1;
      end
      hold = $urandom_range(1, 6) * FR + $urandom_range(0, FR - 1);
      repeat (hold) @(posedge clk);
      #1;
    end
    keys = '0;
    repeat (5 * FR) @(negedge clk);
    @(posedge clk);
    check("rand_pulses", pulses, e_pulses);
    check("rand_code", key_code, e_code);
    check("rand_held", key_held, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
